// File: rtl/iob_timer_mc.sv
// iob_timer_mc: prescaled free-running time base with atomic snapshot and N_CH periodic/one-shot interval channels
module iob_timer_mc #(
  parameter int N_CH = 4,
  parameter int CNT_W = 64,
  parameter int PER_W = 32,
  parameter int PRESC_W = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic [N_CH-1:0]     irq_vec,
  output logic                interrupt
);
  localparam int NW = CNT_W / 32;
  logic req, wr, wr_ctrl, wr_stat, tick, en, srst_q;
  logic [PRESC_W-1:0] presc, presc_act, pcnt;
  logic [CNT_W-1:0] tbase, snap;
  logic [N_CH-1:0] status, irq_en, ch_en, ch_mode, fire;
  logic [PER_W-1:0] period [N_CH];
  logic [PER_W-1:0] ccnt [N_CH];
  logic [DATA_W-1:0] rd;
  assign req = valid & ~ready;
  assign wr = req & |wstrb;
  assign wr_ctrl = wr && address == ADDR_W'(0);
  assign wr_stat = wr && address == ADDR_W'(2);
  // presc_act holds the limit for the current period; a live PRESC below the count forces an early wrap
  assign tick = en && (pcnt >= presc_act || pcnt > presc);
  always_comb begin
    fire = '0;
    for (int i = 0; i < N_CH; i++)
      fire[i] = tick && ch_en[i] && period[i] != '0 && ccnt[i] == PER_W'(1);
  end
  always_comb begin
    rd = '0;
    if (address == ADDR_W'(0)) rd = DATA_W'(en);
    if (address == ADDR_W'(1)) rd = DATA_W'(presc);
    if (address == ADDR_W'(2)) rd = DATA_W'(status);
    if (address == ADDR_W'(3)) rd = DATA_W'(irq_en);
    for (int w = 0; w < NW; w++)
      if (address == ADDR_W'(4 + w)) rd = snap[32*w +: 32];
    for (int i = 0; i < N_CH; i++) begin
      if (address == ADDR_W'(8 + 2*i)) rd = DATA_W'({ch_mode[i], ch_en[i]});
      if (address == ADDR_W'(9 + 2*i)) rd = DATA_W'(period[i]);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
      ready <= 1'b0;
      irq_vec <= '0;
      interrupt <= 1'b0;
      en <= 1'b0;
      srst_q <= 1'b0;
      presc <= '0;
      presc_act <= '0;
      pcnt <= '0;
      tbase <= '0;
      snap <= '0;
      status <= '0;
      irq_en <= '0;
      ch_en <= '0;
      ch_mode <= '0;
      for (int i = 0; i < N_CH; i++) begin
        period[i] <= '0;
        ccnt[i] <= '0;
      end
    end else begin
      ready <= req;
      if (req && !wr) rdata <= rd;
      irq_vec <= status & irq_en;
      interrupt <= |(status & irq_en);
      srst_q <= wr_ctrl & wdata[1];
      if (wr_ctrl) en <= wdata[0];
      if (wr && address == ADDR_W'(1)) presc <= wdata[PRESC_W-1:0];
      if (wr && address == ADDR_W'(3)) irq_en <= wdata[N_CH-1:0];
      status <= srst_q ? '0 : (status & ~(wr_stat ? wdata[N_CH-1:0] : '0)) | fire;
      if (srst_q) begin
        pcnt <= '0;
        presc_act <= presc;
        tbase <= '0;
        snap <= '0;
      end else begin
        if (tick) begin
          pcnt <= '0;
          presc_act <= presc;
          tbase <= tbase + CNT_W'(1);
        end else if (en) pcnt <= pcnt + PRESC_W'(1);
        if (wr_ctrl && wdata[2] && !wdata[1]) snap <= tbase;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (wr && address == ADDR_W'(9 + 2*i)) period[i] <= wdata[PER_W-1:0];
        if (srst_q) begin
          ch_en[i] <= 1'b0;
          ccnt[i] <= '0;
        end else begin
          if (fire[i]) begin
            ccnt[i] <= period[i];
            if (ch_mode[i]) ch_en[i] <= 1'b0;
          end else if (tick && ch_en[i] && period[i] != '0)
            ccnt[i] <= ccnt[i] == '0 ? period[i] : ccnt[i] - PER_W'(1);
          // only a 0->1 enable reloads; rewriting CH_EN=1 keeps the running count
          if (wr && address == ADDR_W'(8 + 2*i)) begin
            ch_en[i] <= wdata[0];
            ch_mode[i] <= wdata[1];
            if (wdata[0] && !ch_en[i]) ccnt[i] <= period[i];
          end
        end
      end
    end
  end
endmodule
